// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: iterative multiply/divide unit with the architectural HI/LO
// registers. It executes MULT, MULTU, DIV, DIVU, MADD, MSUB, MTHI and MTLO and
// retires one radix-2 step per cycle.
//
// Ports:
//   Clk, Rst_n       rising-edge clock, asynchronous active-low reset
//   Start, Op        operation valid and opcode (see OP_* below; others are no-ops)
//   A, B             rs / rt operands, sampled only at the accept edge
//   HiLoRead         MFHI/MFLO is in EX this cycle
//   Busy             sequencer is not idle
//   Stall            (Start | HiLoRead) & Busy, combinational, to the hazard logic
//   Done             one-cycle pulse after HI/LO were written by a multi-cycle op
//   Hi, Lo           architectural HI/LO registers
//
// Optional build macro MULDIV_EARLY_OUT_EN: the multiply finishes as soon as
// the remaining multiplier magnitude is zero. Results are unchanged. Divide
// timing does not change.
module muldiv_sequencer #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic             Start,
  input  logic [3:0]       Op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             HiLoRead,
  output logic             Busy,
  output logic             Stall,
  output logic             Done,
  output logic [WIDTH-1:0] Hi,
  output logic [WIDTH-1:0] Lo
);

  localparam logic [3:0] OP_MULT  = 4'b0000;
  localparam logic [3:0] OP_MULTU = 4'b0001;
  localparam logic [3:0] OP_DIV   = 4'b0010;
  localparam logic [3:0] OP_DIVU  = 4'b0011;
  localparam logic [3:0] OP_MADD  = 4'b0100;
  localparam logic [3:0] OP_MSUB  = 4'b0101;
  localparam logic [3:0] OP_MTHI  = 4'b0110;
  localparam logic [3:0] OP_MTLO  = 4'b0111;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;       // product accumulator
  logic [2*WIDTH-1:0] mcand_q, mcand_d;   // multiplicand, shifted left each step
  logic [WIDTH-1:0]   mplier_q, mplier_d; // multiplier, shifted right each step
  logic [WIDTH-1:0]   rem_q, rem_d;       // partial remainder
  logic [WIDTH-1:0]   quo_q, quo_d;       // dividend in, quotient out (A on div-by-0)
  logic [WIDTH-1:0]   dvsr_q, dvsr_d;
  logic               neg_q, neg_d;       // negate product / quotient
  logic               rneg_q, rneg_d;     // negate remainder (dividend sign)
  logic               dbz_q, dbz_d;
  logic [3:0]         op_q, op_d;
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic               done_q, done_d;

  // operand magnitudes for the signed ops
  logic             op_signed;
  logic [WIDTH-1:0] a_mag, b_mag;
  assign op_signed = (Op == OP_MULT) || (Op == OP_DIV) || (Op == OP_MADD) || (Op == OP_MSUB);
  assign a_mag     = (op_signed && A[WIDTH-1]) ? -A : A;
  assign b_mag     = (op_signed && B[WIDTH-1]) ? -B : B;

  // one restoring-divide step: shift the next dividend bit in and try a subtract
  logic [WIDTH:0] rem_sh, diff;
  assign rem_sh = {rem_q, quo_q[WIDTH-1]};
  assign diff   = rem_sh - {1'b0, dvsr_q};

  logic [WIDTH-1:0] mplier_sh;
  logic             mul_last;
  assign mplier_sh = mplier_q >> 1;
`ifdef MULDIV_EARLY_OUT_EN
  assign mul_last = (cnt_q == LAST) || (mplier_sh == '0);
`else
  assign mul_last = (cnt_q == LAST);
`endif

  // final fix-up values
  logic [2*WIDTH-1:0] prod, hilo, mul_res;
  logic [WIDTH-1:0]   quo_fix, rem_fix;
  assign prod    = neg_q ? -acc_q : acc_q;
  assign hilo    = {hi_q, lo_q};
  assign mul_res = (op_q == OP_MADD) ? hilo + prod :
                   (op_q == OP_MSUB) ? hilo - prod : prod;
  assign quo_fix = neg_q  ? -quo_q : quo_q;
  assign rem_fix = rneg_q ? -rem_q : rem_q;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    dvsr_d   = dvsr_q;
    neg_d    = neg_q;
    rneg_d   = rneg_q;
    dbz_d    = dbz_q;
    op_d     = op_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (Start) begin
          op_d = Op;
          cnt_d = '0;
          unique case (Op)
            OP_MTHI: hi_d = A;
            OP_MTLO: lo_d = A;
            OP_MULT, OP_MULTU, OP_MADD, OP_MSUB: begin
              acc_d    = '0;
              mcand_d  = {{WIDTH{1'b0}}, a_mag};
              mplier_d = b_mag;
              neg_d    = op_signed && (A[WIDTH-1] ^ B[WIDTH-1]);
`ifdef MULDIV_EARLY_OUT_EN
              state_d  = (b_mag == '0) ? S_FIX : S_MUL;
`else
              state_d  = S_MUL;
`endif
            end
            OP_DIV, OP_DIVU: begin
              dbz_d  = (B == '0);
              rem_d  = '0;
              quo_d  = (B == '0) ? A : a_mag;
              dvsr_d = b_mag;
              neg_d  = op_signed && (A[WIDTH-1] ^ B[WIDTH-1]);
              rneg_d = op_signed && A[WIDTH-1];
              state_d = (B == '0) ? S_FIX : S_DIV;
            end
            default: ;
          endcase
        end
      end
      S_MUL: begin
        acc_d    = acc_q + (mplier_q[0] ? mcand_q : '0);
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_sh;
        cnt_d    = cnt_q + CNT_W'(1);
        if (mul_last) state_d = S_FIX;
      end
      S_DIV: begin
        if (!diff[WIDTH]) begin
          rem_d = diff[WIDTH-1:0];
          quo_d = {quo_q[WIDTH-2:0], 1'b1};
        end else begin
          rem_d = rem_sh[WIDTH-1:0];
          quo_d = {quo_q[WIDTH-2:0], 1'b0};
        end
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == LAST) state_d = S_FIX;
      end
      S_FIX: begin
        if ((op_q == OP_DIV) || (op_q == OP_DIVU)) begin
          hi_d = dbz_q ? quo_q : rem_fix;
          lo_d = dbz_q ? '1    : quo_fix;
        end else begin
          {hi_d, lo_d} = mul_res;
        end
        cnt_d   = '0;
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      dvsr_q   <= '0;
      neg_q    <= 1'b0;
      rneg_q   <= 1'b0;
      dbz_q    <= 1'b0;
      op_q     <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      dvsr_q   <= dvsr_d;
      neg_q    <= neg_d;
      rneg_q   <= rneg_d;
      dbz_q    <= dbz_d;
      op_q     <= op_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      done_q   <= done_d;
    end
  end

  assign Busy  = (state_q != S_IDLE);
  assign Stall = (Start || HiLoRead) && Busy;
  assign Done  = done_q;
  assign Hi    = hi_q;
  assign Lo    = lo_q;

endmodule
